tetris_input_ctrl: RTL and testbench

Input front end for the tetris top level. It takes the raw push-buttons and the pause switch and turns them into single game-move commands. Each command is delivered over a valid/ready handshake to the game-logic block. Internally it does per-button synchronization, debouncing, press-edge detection, arbitration and a one-deep command buffer.

---
 rtl/tetris_input_ctrl_if.sv | 25 ++
 rtl/tetris_input_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_tetris_input_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_input_ctrl_if.sv
// -----------------------------------------------------------------------------
// tetris_input_ctrl_if
// Command handshake between the input front end and the game-logic block.
//   cmd_valid : a command is pending (driven by the producer)
//   cmd       : 0 none, 1 left, 2 right, 3 down, 4 rotate, 5 drop
//   cmd_ready : consumer accepts cmd on an edge where cmd_valid is also high
// Modports: master = command producer, slave = command consumer.
// -----------------------------------------------------------------------------
interface tetris_input_ctrl_if;
   logic       cmd_valid;
   logic [2:0] cmd;
   logic       cmd_ready;

   modport master (
      output cmd_valid,
      output cmd,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd,
      output cmd_ready
   );
endinterface

// File: rtl/tetris_input_ctrl.sv
// -----------------------------------------------------------------------------
// tetris_input_ctrl
// Input front end: turns raw push-buttons and the pause switch into single
// game-move commands delivered over a valid/ready handshake.
// Pipeline per button: 2-flop synchronizer -> debounce -> press-edge detect,
// then one registered event stage, fixed-priority arbitration and a one-deep
// command buffer.
//
// Ports:
//   clk        : system clock
//   sw_rst     : asynchronous, active-high reset
//   btn_drop, btn_rotate, btn_left, btn_right, btn_down : raw buttons (async)
//   sw_pause   : raw pause switch (synchronized only)
//   cmd_if     : master side of the command handshake (cmd_valid/cmd/cmd_ready)
//   paused     : synchronized pause level
//   overflow   : sticky, a command event was discarded (cleared by reset only)
//
// Optional build macro: TETRIS_INPUT_REPEAT_EN
//   defined   : left/right/down auto-repeat while held (REPEAT_DELAY after the
//               press, then every REPEAT_PERIOD cycles)
//   undefined : no repeat logic, only press events produce commands
// -----------------------------------------------------------------------------
module tetris_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 8000000,
   parameter int CNT_W           = 25
) (
   input  logic                clk,
   input  logic                sw_rst,
   input  logic                btn_drop,
   input  logic                btn_rotate,
   input  logic                btn_left,
   input  logic                btn_right,
   input  logic                btn_down,
   input  logic                sw_pause,
   tetris_input_ctrl_if.master cmd_if,
   output logic                paused,
   output logic                overflow
);

   // Button index order: 0 left, 1 right, 2 down, 3 rotate, 4 drop.
   // Index i maps to command code i+1.
   localparam int NB = 5;

   localparam int CNT_NEED = (DEBOUNCE_CYCLES > REPEAT_DELAY)
                           ? ((DEBOUNCE_CYCLES > REPEAT_PERIOD) ? DEBOUNCE_CYCLES : REPEAT_PERIOD)
                           : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
   localparam bit CFG_OK = (DEBOUNCE_CYCLES >= 2) && (REPEAT_DELAY >= 1) &&
                           (REPEAT_PERIOD >= 1) && (CNT_NEED < (2 ** CNT_W));

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      CMD_NONE   = 3'd0,
      CMD_LEFT   = 3'd1,
      CMD_RIGHT  = 3'd2,
      CMD_DOWN   = 3'd3,
      CMD_ROTATE = 3'd4,
      CMD_DROP   = 3'd5
   } cmd_e;

   typedef enum logic [0:0] {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_e;

   if (!CFG_OK) begin : g_cfg_bad
      $error("tetris_input_ctrl: DEBOUNCE_CYCLES < 2 or CNT_W too small");
   end

   logic [NB-1:0]    btn_raw_s;
   logic [NB-1:0]    btn_meta_r;
   logic [NB-1:0]    btn_sync_r;
   logic             pause_meta_r;
   logic             pause_sync_r;
   logic [CNT_W-1:0] db_cnt_r [NB];
   logic [NB-1:0]    stable_r;
   logic [NB-1:0]    db_done_s;
   logic [NB-1:0]    press_s;
   logic [NB-1:0]    repeat_s;
   logic [NB-1:0]    event_s;
   logic [NB-1:0]    ev_r;
   cmd_e             win_cmd_s;
   logic             have_win_s;
   logic             lose_s;
   logic             xfer_s;
   buf_state_e       buf_state_r;
   buf_state_e       buf_state_s;
   cmd_e             cmd_r;
   cmd_e             cmd_s;
   logic             overflow_r;
   logic             overflow_s;

   assign btn_raw_s = {btn_drop, btn_rotate, btn_down, btn_right, btn_left};

   // Two-flop synchronizers for every raw input
   always_ff @(posedge clk or posedge sw_rst) begin
      if (sw_rst) begin
         btn_meta_r   <= 5'b0;
         btn_sync_r   <= 5'b0;
         pause_meta_r <= 1'b0;
         pause_sync_r <= 1'b0;
      end else begin
         btn_meta_r   <= btn_raw_s;
         btn_sync_r   <= btn_meta_r;
         pause_meta_r <= sw_pause;
         pause_sync_r <= pause_meta_r;
      end
   end

   // Debounce accept: synchronized level has differed for DEBOUNCE_CYCLES cycles
   always_comb begin
      db_done_s = 5'b0;
      for (int i = 0; i < NB; i++) begin
         db_done_s[i] = (btn_sync_r[i] != stable_r[i]) && (db_cnt_r[i] == DB_LAST);
      end
   end

   // Debounce counters and stable levels; counter clears whenever input agrees
   always_ff @(posedge clk or posedge sw_rst) begin
      if (sw_rst) begin
         stable_r <= 5'b0;
         for (int i = 0; i < NB; i++) begin
            db_cnt_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (db_done_s[i]) begin
               stable_r[i] <= btn_sync_r[i];
               db_cnt_r[i] <= '0;
            end else if (btn_sync_r[i] != stable_r[i]) begin
               db_cnt_r[i] <= db_cnt_r[i] + CNT_ONE;
            end else begin
               db_cnt_r[i] <= '0;
            end
         end
      end
   end

   // A press is the cycle in which stable is being written 0->1
   assign press_s = db_done_s & btn_sync_r;

`ifdef TETRIS_INPUT_REPEAT_EN
   localparam int NR = 3;
   localparam logic [CNT_W-1:0] REP_DELAY_C  = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] REP_PERIOD_C = CNT_W'(REPEAT_PERIOD);

   // rep_cnt_r counts cycles since the last press/repeat event; rep_first_r
   // selects the initial delay versus the steady repeat period.
   logic [CNT_W-1:0] rep_cnt_r [NR];
   logic [NR-1:0]    rep_on_r;
   logic [NR-1:0]    rep_first_r;
   logic [NR-1:0]    rep_fire_s;

   // Repeat fires when the running count reaches the active interval
   always_comb begin
      rep_fire_s = 3'b0;
      for (int i = 0; i < NR; i++) begin
         if (rep_on_r[i] && stable_r[i]) begin
            if (rep_first_r[i]) begin
               rep_fire_s[i] = (rep_cnt_r[i] == REP_DELAY_C);
            end else begin
               rep_fire_s[i] = (rep_cnt_r[i] == REP_PERIOD_C);
            end
         end else begin
            rep_fire_s[i] = 1'b0;
         end
      end
   end

   // Repeat counters for left/right/down; pause or release parks them at 0
   always_ff @(posedge clk or posedge sw_rst) begin
      if (sw_rst) begin
         rep_on_r    <= 3'b0;
         rep_first_r <= 3'b0;
         for (int i = 0; i < NR; i++) begin
            rep_cnt_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NR; i++) begin
            if (pause_sync_r) begin
               rep_cnt_r[i]   <= '0;
               rep_on_r[i]    <= 1'b0;
               rep_first_r[i] <= 1'b0;
            end else if (press_s[i]) begin
               rep_cnt_r[i]   <= CNT_ONE;
               rep_on_r[i]    <= 1'b1;
               rep_first_r[i] <= 1'b1;
            end else if (!stable_r[i] || !rep_on_r[i]) begin
               rep_cnt_r[i]   <= '0;
               rep_on_r[i]    <= 1'b0;
               rep_first_r[i] <= 1'b0;
            end else if (rep_fire_s[i]) begin
               rep_cnt_r[i]   <= CNT_ONE;
               rep_first_r[i] <= 1'b0;
            end else begin
               rep_cnt_r[i]   <= rep_cnt_r[i] + CNT_ONE;
            end
         end
      end
   end

   assign repeat_s = {2'b00, rep_fire_s};
`else
   assign repeat_s = 5'b0;
`endif

   // No events at all while paused
   assign event_s = pause_sync_r ? 5'b0 : (press_s | repeat_s);

   // Event stage register; all same-cycle events stay together for arbitration
   always_ff @(posedge clk or posedge sw_rst) begin
      if (sw_rst) begin
         ev_r <= 5'b0;
      end else begin
         ev_r <= event_s;
      end
   end

   // Fixed priority: drop > rotate > left > right > down
   always_comb begin
      win_cmd_s = CMD_NONE;
      if (ev_r[4]) begin
         win_cmd_s = CMD_DROP;
      end else if (ev_r[3]) begin
         win_cmd_s = CMD_ROTATE;
      end else if (ev_r[0]) begin
         win_cmd_s = CMD_LEFT;
      end else if (ev_r[1]) begin
         win_cmd_s = CMD_RIGHT;
      end else if (ev_r[2]) begin
         win_cmd_s = CMD_DOWN;
      end else begin
         win_cmd_s = CMD_NONE;
      end
   end

   assign have_win_s = (ev_r != 5'b0);
   // More than one bit set means at least one event lost arbitration
   assign lose_s     = ((ev_r & (ev_r - 5'd1)) != 5'b0);
   assign xfer_s     = (buf_state_r == BUF_FULL) && cmd_if.cmd_ready;

   // Buffer next-state: load, drain, reload on a transfer edge, or discard
   always_comb begin
      buf_state_s = buf_state_r;
      cmd_s       = cmd_r;
      overflow_s  = overflow_r;
      if (pause_sync_r) begin
         buf_state_s = BUF_EMPTY;
         cmd_s       = CMD_NONE;
      end else begin
         if (lose_s) begin
            overflow_s = 1'b1;
         end else begin
            overflow_s = overflow_r;
         end
         case (buf_state_r)
            BUF_EMPTY: begin
               if (have_win_s) begin
                  buf_state_s = BUF_FULL;
                  cmd_s       = win_cmd_s;
               end else begin
                  buf_state_s = BUF_EMPTY;
                  cmd_s       = CMD_NONE;
               end
            end
            BUF_FULL: begin
               if (xfer_s) begin
                  if (have_win_s) begin
                     buf_state_s = BUF_FULL;
                     cmd_s       = win_cmd_s;
                  end else begin
                     buf_state_s = BUF_EMPTY;
                     cmd_s       = CMD_NONE;
                  end
               end else if (have_win_s) begin
                  overflow_s = 1'b1;
               end else begin
                  buf_state_s = BUF_FULL;
               end
            end
            default: begin
               buf_state_s = BUF_EMPTY;
               cmd_s       = CMD_NONE;
            end
         endcase
      end
   end

   // Buffer state, command and sticky overflow registers
   always_ff @(posedge clk or posedge sw_rst) begin
      if (sw_rst) begin
         buf_state_r <= BUF_EMPTY;
         cmd_r       <= CMD_NONE;
         overflow_r  <= 1'b0;
      end else begin
         buf_state_r <= buf_state_s;
         cmd_r       <= cmd_s;
         overflow_r  <= overflow_s;
      end
   end

   assign cmd_if.cmd_valid = (buf_state_r == BUF_FULL);
   assign cmd_if.cmd       = cmd_r;
   assign paused           = pause_sync_r;
   assign overflow         = overflow_r;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tetris_input_ctrl
// Directed bench for tetris_input_ctrl with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=5. "Edge e" is the e-th rising edge after a stimulus change;
// outputs are sampled 1 ns after each edge.
// -----------------------------------------------------------------------------
module tb_tetris_input_ctrl;

   logic clk;
   logic sw_rst;
   logic btn_drop;
   logic btn_rotate;
   logic btn_left;
   logic btn_right;
   logic btn_down;
   logic sw_pause;
   logic paused;
   logic overflow;

   int n_tests;
   int n_fail;

   tetris_input_ctrl_if cmd_bus ();

   tetris_input_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (5),
      .CNT_W           (8)
   ) dut (
      .clk        (clk),
      .sw_rst     (sw_rst),
      .btn_drop   (btn_drop),
      .btn_rotate (btn_rotate),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_down   (btn_down),
      .sw_pause   (sw_pause),
      .cmd_if     (cmd_bus),
      .paused     (paused),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic test_reset();
      sw_rst = 1'b1;
      btn_drop = 1'b0; btn_rotate = 1'b0; btn_left = 1'b0;
      btn_right = 1'b0; btn_down = 1'b0; sw_pause = 1'b0;
      cmd_bus.cmd_ready = 1'b0;
      #2;
      n_tests++;
      if (cmd_bus.cmd_valid !== 1'b0 || cmd_bus.cmd !== 3'd0 ||
          paused !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b cmd=%0d paused=%b ovf=%b, want 0 0 0 0",
                  cmd_bus.cmd_valid, cmd_bus.cmd, paused, overflow);
      end
      idle(2);
      sw_rst = 1'b0;
      idle(3);
   endtask

   // Held left: exactly one pulse after edge 6, nothing on release
   task automatic test_single_press();
      cmd_bus.cmd_ready = 1'b1;
      btn_left = 1'b1;
      for (int e = 0; e <= 16; e++) begin
         tick();
         n_tests++;
         if (cmd_bus.cmd_valid !== (e == 6)) begin
            n_fail++;
            $display("FAIL single_valid e=%0d: got %b want %b", e, cmd_bus.cmd_valid, (e == 6));
         end
         if (e == 6) begin
            n_tests++;
            if (cmd_bus.cmd !== 3'd1) begin
               n_fail++;
               $display("FAIL single_cmd: got %0d want 1", cmd_bus.cmd);
            end
         end
         if (e == 7) btn_left = 1'b0;
      end
      n_tests++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL single_ovf: got %b want 0", overflow);
      end
      idle(5);
   endtask

   // Three raw samples high is one short of the debounce window
   task automatic test_glitch();
      cmd_bus.cmd_ready = 1'b1;
      btn_rotate = 1'b1;
      for (int e = 0; e <= 14; e++) begin
         tick();
         if (e == 2) btn_rotate = 1'b0;
         n_tests++;
         if (cmd_bus.cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch e=%0d: got valid %b want 0", e, cmd_bus.cmd_valid);
         end
      end
   endtask

   task automatic test_priority_overflow();
      cmd_bus.cmd_ready = 1'b0;
      btn_drop = 1'b1;
      btn_down = 1'b1;
      for (int e = 0; e <= 8; e++) begin
         tick();
         n_tests++;
         if (cmd_bus.cmd_valid !== (e >= 6)) begin
            n_fail++;
            $display("FAIL prio_valid e=%0d: got %b want %b", e, cmd_bus.cmd_valid, (e >= 6));
         end
         n_tests++;
         if (overflow !== (e >= 6)) begin
            n_fail++;
            $display("FAIL prio_ovf e=%0d: got %b want %b", e, overflow, (e >= 6));
         end
      end
      n_tests++;
      if (cmd_bus.cmd !== 3'd5) begin
         n_fail++;
         $display("FAIL prio_cmd: got %0d want 5", cmd_bus.cmd);
      end
      btn_right = 1'b1;
      for (int e = 0; e < 10; e++) begin
         tick();
         n_tests++;
         if (cmd_bus.cmd_valid !== 1'b1 || cmd_bus.cmd !== 3'd5) begin
            n_fail++;
            $display("FAIL full_hold e=%0d: valid=%b cmd=%0d want 1 5", e, cmd_bus.cmd_valid, cmd_bus.cmd);
         end
      end
      cmd_bus.cmd_ready = 1'b1;
      tick();
      n_tests++;
      if (cmd_bus.cmd_valid !== 1'b0 || cmd_bus.cmd !== 3'd0) begin
         n_fail++;
         $display("FAIL drain: valid=%b cmd=%0d want 0 0", cmd_bus.cmd_valid, cmd_bus.cmd);
      end
      btn_drop = 1'b0; btn_down = 1'b0; btn_right = 1'b0;
      idle(20);
   endtask

   task automatic test_reset_async();
      cmd_bus.cmd_ready = 1'b0;
      btn_left = 1'b1;
      idle(8);
      n_tests++;
      if (cmd_bus.cmd_valid !== 1'b1 || cmd_bus.cmd !== 3'd1) begin
         n_fail++;
         $display("FAIL pre_reset: valid=%b cmd=%0d want 1 1", cmd_bus.cmd_valid, cmd_bus.cmd);
      end
      #2;
      sw_rst = 1'b1;
      btn_left = 1'b0;
      #1;
      n_tests++;
      if (cmd_bus.cmd_valid !== 1'b0 || cmd_bus.cmd !== 3'd0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: valid=%b cmd=%0d ovf=%b want 0 0 0",
                  cmd_bus.cmd_valid, cmd_bus.cmd, overflow);
      end
      tick();
      sw_rst = 1'b0;
      idle(5);
   endtask

   task automatic test_pause();
      cmd_bus.cmd_ready = 1'b1;
      sw_pause = 1'b1;
      idle(3);
      n_tests++;
      if (paused !== 1'b1) begin
         n_fail++;
         $display("FAIL paused_level: got %b want 1", paused);
      end
      btn_left = 1'b1;
      for (int e = 0; e < 15; e++) begin
         tick();
         n_tests++;
         if (cmd_bus.cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_block e=%0d: got valid %b want 0", e, cmd_bus.cmd_valid);
         end
      end
      sw_pause = 1'b0;
      for (int e = 0; e < 30; e++) begin
         tick();
         n_tests++;
         if (cmd_bus.cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL unpause_held e=%0d: got valid %b want 0", e, cmd_bus.cmd_valid);
         end
      end
      n_tests++;
      if (paused !== 1'b0) begin
         n_fail++;
         $display("FAIL unpaused_level: got %b want 0", paused);
      end
      btn_left = 1'b0;
      idle(10);
      btn_left = 1'b1;
      for (int e = 0; e <= 8; e++) begin
         tick();
         n_tests++;
         if (cmd_bus.cmd_valid !== (e == 6)) begin
            n_fail++;
            $display("FAIL repress e=%0d: got %b want %b", e, cmd_bus.cmd_valid, (e == 6));
         end
         if (e == 7) btn_left = 1'b0;
      end
      idle(10);
   endtask

   task automatic test_repeat();
      logic exp_v;
      cmd_bus.cmd_ready = 1'b1;
      btn_right = 1'b1;
`ifdef TETRIS_INPUT_REPEAT_EN
      for (int e = 0; e <= 26; e++) begin
         tick();
         exp_v = (e == 6) || (e == 16) || (e == 21) || (e == 26);
         n_tests++;
         if (cmd_bus.cmd_valid !== exp_v) begin
            n_fail++;
            $display("FAIL repeat_valid e=%0d: got %b want %b", e, cmd_bus.cmd_valid, exp_v);
         end
         if (exp_v) begin
            n_tests++;
            if (cmd_bus.cmd !== 3'd2) begin
               n_fail++;
               $display("FAIL repeat_cmd e=%0d: got %0d want 2", e, cmd_bus.cmd);
            end
         end
      end
      btn_right = 1'b0;
      idle(8);
      for (int e = 0; e < 15; e++) begin
         tick();
         n_tests++;
         if (cmd_bus.cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL repeat_stop e=%0d: got valid %b want 0", e, cmd_bus.cmd_valid);
         end
      end
`else
      for (int e = 0; e <= 30; e++) begin
         tick();
         exp_v = (e == 6);
         n_tests++;
         if (cmd_bus.cmd_valid !== exp_v) begin
            n_fail++;
            $display("FAIL norepeat_valid e=%0d: got %b want %b", e, cmd_bus.cmd_valid, exp_v);
         end
      end
      btn_right = 1'b0;
      idle(10);
`endif
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_single_press();
      test_glitch();
      test_priority_overflow();
      test_reset_async();
      test_pause();
      test_repeat();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
